// File: rtl/ssd13xx_ctrl_if.sv
// ----------------------------------------------------------------------------
// ssd13xx_ctrl_if
// Byte-stream bus from the SPI slave into the OLED controller core.
//   cs_n_i       : chip select, active low
//   byte_valid_i : one-cycle strobe, byte_i/dc_i valid
//   byte_i       : received byte
//   dc_i         : 1 = data byte, 0 = command byte
// master modport drives the bus (SPI slave / testbench),
// slave modport receives it (ssd13xx_ctrl).
// ----------------------------------------------------------------------------
interface ssd13xx_ctrl_if;
  logic       cs_n_i;
  logic       byte_valid_i;
  logic [7:0] byte_i;
  logic       dc_i;

  modport master (output cs_n_i, output byte_valid_i, output byte_i, output dc_i);
  modport slave  (input  cs_n_i, input  byte_valid_i, input  byte_i, input  dc_i);
endinterface

// File: rtl/ssd13xx_ctrl.sv
// ----------------------------------------------------------------------------
// ssd13xx_ctrl
// SSD1306/SSD1309-class OLED controller core. Decodes the command/data byte
// stream, writes display RAM using horizontal, vertical or page addressing
// inside column/page windows, and serves a one-cycle-latency raster read port
// with segment remap, COM scan direction, start-line scroll, invert and
// entire-display-on applied.
// Ports:
//   clk_i      : the only clock
//   rst_i      : synchronous active-high reset
//   bus        : byte stream (cs_n_i, byte_valid_i, byte_i, dc_i), slave side
//   rd_x_i     : raster column, panel coordinates
//   rd_y_i     : raster row, panel coordinates
//   rd_pix_o   : pixel for the coordinates presented one cycle earlier
//   disp_on_o  : display on (AF) / off (AE)
//   contrast_o : last 0x81 argument
// ----------------------------------------------------------------------------
module ssd13xx_ctrl #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  ssd13xx_ctrl_if.slave             bus,
  input  logic [$clog2(WIDTH)-1:0]  rd_x_i,
  input  logic [$clog2(HEIGHT)-1:0] rd_y_i,
  output logic                      rd_pix_o,
  output logic                      disp_on_o,
  output logic [7:0]                contrast_o
);

  localparam int PAGES = HEIGHT / 8;
  localparam int CW    = $clog2(WIDTH);
  localparam int PW    = $clog2(PAGES);
  localparam int RW    = $clog2(HEIGHT);
  localparam int DEPTH = PAGES * WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ARGS = 1'b1;

  localparam logic [1:0] MODE_HORZ = 2'd0;
  localparam logic [1:0] MODE_VERT = 2'd1;
  localparam logic [1:0] MODE_PAGE = 2'd2;

  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [PW-1:0] PAGE_ONE = PW'(1);

  // Number of argument bytes that follow each multi-byte opcode.
  function automatic logic [2:0] argCount(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB:          argCount = 3'd1;
      8'h21, 8'h22, 8'hA3:                 argCount = 3'd2;
      8'h29, 8'h2A:                        argCount = 3'd5;
      8'h26, 8'h27:                        argCount = 3'd6;
      default:                             argCount = 3'd0;
    endcase
  endfunction

  logic [0:0]    r_state;
  logic [2:0]    r_argCnt;
  logic [7:0]    r_opcode;
  logic [1:0]    r_mode;
  logic          r_invert;
  logic          r_entireOn;
  logic          r_segRemap;
  logic          r_comDec;
  logic          r_dispOn;
  logic [7:0]    r_contrast;
  logic [RW-1:0] r_startLine;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_colStart;
  logic [CW-1:0] r_colEnd;
  logic [PW-1:0] r_page;
  logic [PW-1:0] r_pageStart;
  logic [PW-1:0] r_pageEnd;

  logic [7:0]    r_mem [0:DEPTH-1];
  logic [7:0]    r_rdByte;
  logic [2:0]    r_rdBit;
  logic          r_rdDisp;
  logic          r_rdEntire;
  logic          r_rdInv;

  logic          w_accept;
  logic          w_write;
  logic [7:0]    w_nArgs;
  logic [CW-1:0] w_cx;
  logic [RW-1:0] w_ry;
  logic [RW-1:0] w_r;

  assign w_accept = bus.byte_valid_i && !bus.cs_n_i;
  assign w_write  = w_accept && !rst_i && (r_state == ST_IDLE) && bus.dc_i;
  assign w_nArgs  = {5'd0, argCount(bus.byte_i)};

  // Decoder, mode registers and address pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_argCnt    <= 3'd0;
      r_opcode    <= 8'h00;
      r_mode      <= MODE_PAGE;
      r_invert    <= 1'b0;
      r_entireOn  <= 1'b0;
      r_segRemap  <= 1'b0;
      r_comDec    <= 1'b0;
      r_dispOn    <= 1'b0;
      r_contrast  <= 8'h7F;
      r_startLine <= '0;
      r_col       <= '0;
      r_colStart  <= '0;
      r_colEnd    <= '1;
      r_page      <= '0;
      r_pageStart <= '0;
      r_pageEnd   <= '1;
    end else if (bus.cs_n_i) begin
      // Deselect aborts any half-received command; pointers survive.
      r_state  <= ST_IDLE;
      r_argCnt <= 3'd0;
      r_opcode <= 8'h00;
    end else if (bus.byte_valid_i) begin
      if (r_state == ST_ARGS) begin
        // Arguments are consumed regardless of dc_i.
        case (r_opcode)
          8'h20: r_mode <= (bus.byte_i[1:0] == 2'd3) ? MODE_PAGE : bus.byte_i[1:0];
          8'h21: begin
            if (r_argCnt == 3'd2) begin
              r_colStart <= bus.byte_i[CW-1:0];
            end else begin
              r_colEnd <= bus.byte_i[CW-1:0];
              r_col    <= r_colStart;
            end
          end
          8'h22: begin
            if (r_argCnt == 3'd2) begin
              r_pageStart <= bus.byte_i[PW-1:0];
            end else begin
              r_pageEnd <= bus.byte_i[PW-1:0];
              r_page    <= r_pageStart;
            end
          end
          8'h81:   r_contrast <= bus.byte_i;
          default: ;
        endcase
        r_argCnt <= r_argCnt - 3'd1;
        if (r_argCnt == 3'd1) begin
          r_state <= ST_IDLE;
        end
      end else if (bus.dc_i) begin
        // Pointer advance after the RAM write of this data byte.
        case (r_mode)
          MODE_HORZ: begin
            if (r_col == r_colEnd) begin
              r_col  <= r_colStart;
              r_page <= (r_page == r_pageEnd) ? r_pageStart : r_page + PAGE_ONE;
            end else begin
              r_col <= r_col + COL_ONE;
            end
          end
          MODE_VERT: begin
            if (r_page == r_pageEnd) begin
              r_page <= r_pageStart;
              r_col  <= (r_col == r_colEnd) ? r_colStart : r_col + COL_ONE;
            end else begin
              r_page <= r_page + PAGE_ONE;
            end
          end
          default: r_col <= r_col + COL_ONE;
        endcase
      end else if (w_nArgs != 8'd0) begin
        r_opcode <= bus.byte_i;
        r_argCnt <= w_nArgs[2:0];
        r_state  <= ST_ARGS;
      end else if (bus.byte_i[7:4] == 4'h0) begin
        r_col[3:0] <= bus.byte_i[3:0];
      end else if (bus.byte_i[7:4] == 4'h1) begin
        r_col[CW-1:4] <= bus.byte_i[CW-5:0];
      end else if (bus.byte_i[7:6] == 2'b01) begin
        r_startLine <= bus.byte_i[RW-1:0];
      end else if (bus.byte_i[7:3] == 5'b10110) begin
        r_page <= bus.byte_i[PW-1:0];
      end else begin
        case (bus.byte_i)
          8'hA0:   r_segRemap <= 1'b0;
          8'hA1:   r_segRemap <= 1'b1;
          8'hC0:   r_comDec   <= 1'b0;
          8'hC8:   r_comDec   <= 1'b1;
          8'hA4:   r_entireOn <= 1'b0;
          8'hA5:   r_entireOn <= 1'b1;
          8'hA6:   r_invert   <= 1'b0;
          8'hA7:   r_invert   <= 1'b1;
          8'hAE:   r_dispOn   <= 1'b0;
          8'hAF:   r_dispOn   <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // WIDTH and HEIGHT are powers of two, so N-1-x is the bitwise complement.
  assign w_cx = r_segRemap ? ~rd_x_i : rd_x_i;
  assign w_ry = r_comDec   ? ~rd_y_i : rd_y_i;
  assign w_r  = w_ry + r_startLine;

  // Display RAM: write on the strobe edge, registered read returns old data.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[{r_page, r_col}] <= bus.byte_i;
    end
    r_rdByte <= r_mem[{w_r[RW-1:3], w_cx}];
  end

  // Flags are captured with the read so they line up with the fetched byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdBit    <= 3'd0;
      r_rdDisp   <= 1'b0;
      r_rdEntire <= 1'b0;
      r_rdInv    <= 1'b0;
    end else begin
      r_rdBit    <= w_r[2:0];
      r_rdDisp   <= r_dispOn;
      r_rdEntire <= r_entireOn;
      r_rdInv    <= r_invert;
    end
  end

  assign rd_pix_o   = r_rdDisp && (r_rdEntire || (r_rdByte[r_rdBit] ^ r_rdInv));
  assign disp_on_o  = r_dispOn;
  assign contrast_o = r_contrast;

endmodule

// File: tb/tb_ssd13xx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ssd13xx_ctrl
// Directed testbench for ssd13xx_ctrl at the default 128x64 geometry.
// RAM contents are observed through the raster port with all display
// transforms neutral unless a step deliberately enables one.
// ----------------------------------------------------------------------------
module tb_ssd13xx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rdX = '0;
  logic [5:0] rdY = '0;
  logic       rdPix;
  logic       dispOn;
  logic [7:0] contrast;
  logic       pix;

  int compared   = 0;
  int mismatched = 0;

  ssd13xx_ctrl_if bus ();

  ssd13xx_ctrl #(.WIDTH(128), .HEIGHT(64)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus.slave),
    .rd_x_i     (rdX),
    .rd_y_i     (rdY),
    .rd_pix_o   (rdPix),
    .disp_on_o  (dispOn),
    .contrast_o (contrast)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Present one byte on the next falling edge; it is taken on the rising edge
  // that follows. Consecutive calls give back-to-back strobes.
  task automatic applyStimulus(input logic dc, input logic [7:0] b);
    @(negedge clk);
    bus.cs_n_i       = 1'b0;
    bus.byte_valid_i = 1'b1;
    bus.dc_i         = dc;
    bus.byte_i       = b;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    bus.dc_i         = 1'b0;
    bus.byte_i       = 8'h00;
  endtask

  task automatic sendCmd(input logic [7:0] b);
    applyStimulus(1'b0, b);
    idleCycle();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  // Coordinates go in on a falling edge, the pixel is sampled one full cycle later.
  task automatic checkPix(input string tag, input int x, input int y, input logic expected);
    @(negedge clk);
    rdX = 7'(x);
    rdY = 6'(y);
    @(negedge clk);
    pix = rdPix;
    checkOutput(tag, {7'd0, pix}, {7'd0, expected});
  endtask

  initial begin
    bus.cs_n_i       = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.dc_i         = 1'b0;
    bus.byte_i       = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_disp_on", {7'd0, dispOn}, 8'h00);
    checkOutput("rst_contrast", contrast, 8'h7F);
    checkOutput("rst_pix", {7'd0, rdPix}, 8'h00);

    $display("[TB] horizontal fill of 1024 bytes");
    sendCmd(8'hAF);
    checkOutput("disp_on_af", {7'd0, dispOn}, 8'h01);
    sendCmd(8'h20); sendCmd(8'h00);
    sendCmd(8'h21); sendCmd(8'h00); sendCmd(8'h7F);
    sendCmd(8'h22); sendCmd(8'h00); sendCmd(8'h07);
    for (int n = 0; n < 1024; n++) begin
      applyStimulus(1'b1, 8'(n));
    end
    idleCycle();
    // byte at (p3,c5) = 389 mod 256 = 0x85
    checkPix("fill_p3c5_b0", 5, 24, 1'b1);
    checkPix("fill_p3c5_b1", 5, 25, 1'b0);
    checkPix("fill_p3c5_b7", 5, 31, 1'b1);
    // (p7,c127) = 0xFF, (p0,c0) = 0x00, (p0,c1) = 0x01
    checkPix("fill_p7c127_b4", 127, 60, 1'b1);
    checkPix("fill_p0c0_b0", 0, 0, 1'b0);
    checkPix("fill_p0c1_b0", 1, 0, 1'b1);
    checkPix("fill_p0c1_b1", 1, 1, 1'b0);
    // Pointer wrapped back to (p0,c0).
    applyStimulus(1'b1, 8'hFF);
    idleCycle();
    checkPix("wrap_p0c0_b0", 0, 0, 1'b1);
    checkPix("wrap_p0c0_b7", 0, 7, 1'b1);

    $display("[TB] vertical mode in a 2x2 window");
    sendCmd(8'h20); sendCmd(8'h01);
    sendCmd(8'h21); sendCmd(8'h10); sendCmd(8'h11);
    sendCmd(8'h22); sendCmd(8'h02); sendCmd(8'h03);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h04);
    applyStimulus(1'b1, 8'h08);
    applyStimulus(1'b1, 8'h10);
    idleCycle();
    checkPix("vert_p2c16_b4", 16, 20, 1'b1);
    checkPix("vert_p2c16_b0", 16, 16, 1'b0);
    checkPix("vert_p3c16_b1", 16, 25, 1'b1);
    checkPix("vert_p2c17_b2", 17, 18, 1'b1);
    checkPix("vert_p3c17_b3", 17, 27, 1'b1);
    checkPix("vert_p3c17_b0", 17, 24, 1'b0);

    $display("[TB] page mode column wrap");
    sendCmd(8'h20); sendCmd(8'h02);
    sendCmd(8'h21); sendCmd(8'h00); sendCmd(8'h7F);
    sendCmd(8'h22); sendCmd(8'h00); sendCmd(8'h07);
    sendCmd(8'hB5); sendCmd(8'h0F); sendCmd(8'h17);
    applyStimulus(1'b1, 8'h80);
    applyStimulus(1'b1, 8'h40);
    applyStimulus(1'b1, 8'h01);
    idleCycle();
    checkPix("page_p5c127_b7", 127, 47, 1'b1);
    checkPix("page_p5c127_b0", 127, 40, 1'b0);
    checkPix("page_p5c0_b6", 0, 46, 1'b1);
    checkPix("page_p5c0_b7", 0, 47, 1'b0);
    checkPix("page_p5c1_b7", 1, 47, 1'b0);
    checkPix("page_p5c1_b0", 1, 40, 1'b1);

    $display("[TB] aborted contrast command");
    sendCmd(8'h81);
    @(negedge clk); bus.cs_n_i = 1'b1;
    @(negedge clk); bus.cs_n_i = 1'b0;
    applyStimulus(1'b1, 8'h3C);
    idleCycle();
    checkOutput("abort_contrast_kept", contrast, 8'h7F);
    checkPix("abort_data_p5c2_b2", 2, 42, 1'b1);
    checkPix("abort_data_p5c2_b1", 2, 41, 1'b0);
    // Byte strobed while deselected must not reach RAM; (p5,c3) stays 0x83.
    @(negedge clk);
    bus.cs_n_i       = 1'b1;
    bus.byte_valid_i = 1'b1;
    bus.dc_i         = 1'b1;
    bus.byte_i       = 8'hFF;
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    bus.cs_n_i       = 1'b0;
    checkPix("cs_high_p5c3_b2", 3, 42, 1'b0);
    sendCmd(8'h81); sendCmd(8'h55);
    checkOutput("contrast_55", contrast, 8'h55);

    $display("[TB] raster transforms");
    sendCmd(8'hB0); sendCmd(8'h00); sendCmd(8'h10);
    // 0x05: bit 0 for the unscrolled reads, bit 2 for row 62 under C8 plus
    // a start line of 1 (ry = 1, r = 2).
    applyStimulus(1'b1, 8'h05);
    idleCycle();
    checkPix("raw_0_0", 0, 0, 1'b1);
    checkPix("raw_0_1", 0, 1, 1'b0);
    sendCmd(8'hA1);
    checkPix("segremap_127_0", 127, 0, 1'b1);
    sendCmd(8'hC8);
    checkPix("comdec_127_63", 127, 63, 1'b1);
    sendCmd(8'h41);
    checkPix("scroll_127_62", 127, 62, 1'b1);
    checkPix("scroll_127_63", 127, 63, 1'b0);
    sendCmd(8'hA7);
    checkPix("invert_127_62", 127, 62, 1'b0);
    sendCmd(8'hA5);
    checkPix("entire_on_127_62", 127, 62, 1'b1);
    sendCmd(8'hAE);
    checkPix("disp_off_127_62", 127, 62, 1'b0);
    checkOutput("disp_on_ae", {7'd0, dispOn}, 8'h00);
    sendCmd(8'hAF); sendCmd(8'hA4); sendCmd(8'hA6);
    sendCmd(8'hA0); sendCmd(8'hC0); sendCmd(8'h40);

    $display("[TB] scroll command swallows data-flagged arguments");
    // Pointer is at (p0,c1), which holds 0x01 from the fill.
    applyStimulus(1'b0, 8'h26);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'hFF);
    end
    applyStimulus(1'b1, 8'h02);
    idleCycle();
    checkPix("scroll_args_p0c1_b1", 1, 1, 1'b1);
    checkPix("scroll_args_p0c1_b0", 1, 0, 1'b0);
    checkPix("scroll_args_p0c2_b7", 2, 7, 1'b0);
    checkPix("scroll_args_p0c6_b7", 6, 7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
